// File: rtl/conv_relu_pool_stream.sv
// Streaming conv post-processing: optional ReLU, then bypass or POOL x POOL max pooling
// through a one-row running-max buffer, with a frame-done pulse after each map.
module conv_relu_pool_stream #(
  parameter int DW       = 16,
  parameter int OUT_SIZE = 26,
  parameter int POOL     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_mode,
  input  logic                 i_relu_en,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_data,
  output logic                 o_en,
  output logic signed [DW-1:0] o_data,
  output logic                 o_frame_done
);

  localparam int POOL_OUT = OUT_SIZE / POOL;
  localparam int LIM      = POOL_OUT * POOL;
  localparam int CW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int PW       = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int BW       = (POOL_OUT > 1) ? $clog2(POOL_OUT) : 1;

  localparam logic [CW-1:0] POS_LAST = CW'(OUT_SIZE - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(POOL - 1);
  localparam logic [BW-1:0] PC_LAST  = BW'(POOL_OUT - 1);
  localparam logic [CW:0]   LIM_W    = (CW + 1)'(LIM);

  logic [CW-1:0] row, col;
  logic [PW-1:0] rp, cp;
  logic [BW-1:0] pc;
  logic          mode_q, relu_q;

  logic signed [DW-1:0] row_buf [POOL_OUT];

  logic                 frame_start, eff_mode, eff_relu;
  logic                 in_win, win_first, win_last, pool_fire, frame_last;
  logic signed [DW-1:0] x, cur, pool_max, buf_next;

  // Mode and ReLU come straight from the inputs on the first pixel, from the latch afterwards
  always_comb begin
    frame_start = (row == '0) && (col == '0);
    eff_mode    = frame_start ? i_mode    : mode_q;
    eff_relu    = frame_start ? i_relu_en : relu_q;
    x           = (eff_relu && i_data[DW-1]) ? '0 : i_data;
    in_win      = ({1'b0, row} < LIM_W) && ({1'b0, col} < LIM_W);
    win_first   = (rp == '0) && (cp == '0);
    win_last    = (rp == PH_LAST) && (cp == PH_LAST);
    cur         = row_buf[pc];
    pool_max    = (cur > x) ? cur : x;
    buf_next    = win_first ? x : pool_max;
    pool_fire   = in_win && win_last;
    frame_last  = (row == POS_LAST) && (col == POS_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row          <= '0;
      col          <= '0;
      rp           <= '0;
      cp           <= '0;
      pc           <= '0;
      mode_q       <= 1'b0;
      relu_q       <= 1'b0;
      o_en         <= 1'b0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
    end else if (i_clear) begin
      row          <= '0;
      col          <= '0;
      rp           <= '0;
      cp           <= '0;
      pc           <= '0;
      o_en         <= 1'b0;
      o_frame_done <= 1'b0;
    end else if (i_en) begin
      if (frame_start) begin
        mode_q <= i_mode;
        relu_q <= i_relu_en;
      end
      if (eff_mode) begin
        o_en <= pool_fire;
        if (pool_fire) o_data <= pool_max;
      end else begin
        o_en   <= 1'b1;
        o_data <= x;
      end
      o_frame_done <= frame_last;
      // pc saturates so discarded trailing columns never index past the buffer
      if (col == POS_LAST) begin
        col <= '0;
        cp  <= '0;
        pc  <= '0;
        if (row == POS_LAST) begin
          row <= '0;
          rp  <= '0;
        end else begin
          row <= row + 1'b1;
          rp  <= (rp == PH_LAST) ? '0 : rp + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        if (cp == PH_LAST) begin
          cp <= '0;
          if (pc != PC_LAST) pc <= pc + 1'b1;
        end else begin
          cp <= cp + 1'b1;
        end
      end
    end else begin
      o_en         <= 1'b0;
      o_frame_done <= 1'b0;
    end
  end

  // Buffer needs no reset: the first pixel of every window overwrites its slot
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_clear && i_en && eff_mode && in_win)
      row_buf[pc] <= buf_next;
  end

endmodule

// File: tb/tb_conv_relu_pool_stream.sv
// Scoreboard bench for conv_relu_pool_stream: a 4x4 and a 5x5 instance, both with 2x2 pooling.
`timescale 1ns/1ps
module tb_conv_relu_pool_stream;

  typedef struct {
    int                 cyc;
    logic               en;
    logic               fd;
    logic signed [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst, clear, mode, relu, en4, en5;
  logic signed [15:0] din;
  logic               o_en4, o_fd4, o_en5, o_fd5;
  logic signed [15:0] o_data4, o_data5;

  exp_t q4[$];
  exp_t q5[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  conv_relu_pool_stream #(.DW(16), .OUT_SIZE(4), .POOL(2)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_mode(mode), .i_relu_en(relu),
    .i_en(en4), .i_data(din), .o_en(o_en4), .o_data(o_data4), .o_frame_done(o_fd4)
  );

  conv_relu_pool_stream #(.DW(16), .OUT_SIZE(5), .POOL(2)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_mode(mode), .i_relu_en(relu),
    .i_en(en5), .i_data(din), .o_en(o_en5), .o_data(o_data5), .o_frame_done(o_fd5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one pixel; if it completes a result, queue what must appear on the next cycle
  task automatic applyStimulus(input bit sel5, input int d, input bit m, input bit r,
                               input bit has_out, input int exp_d, input bit exp_fd);
    exp_t e;
    @(posedge clk);
    #1;
    en4  = !sel5;
    en5  = sel5;
    din  = 16'(d);
    mode = m;
    relu = r;
    if (has_out || exp_fd) begin
      e.cyc  = cyc + 1;
      e.en   = has_out;
      e.fd   = exp_fd;
      e.data = 16'(exp_d);
      if (sel5) q5.push_back(e);
      else      q4.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      en4 = 1'b0;
      en5 = 1'b0;
    end
  endtask

  task automatic abortFrame(input bit use_rst);
    @(posedge clk);
    #1;
    en4 = 1'b0;
    en5 = 1'b0;
    if (use_rst) rst = 1'b1;
    else         clear = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    clear = 1'b0;
  endtask

  // Pop and compare whenever an instance shows o_en or o_frame_done; stale heads count as missed
  task automatic checkOutput(input bit sel5, input logic en, input logic fd,
                             input logic signed [15:0] d);
    exp_t head;
    bit   have;
    have = sel5 ? (q5.size() > 0) : (q4.size() > 0);
    if (have) head = sel5 ? q5[0] : q4[0];
    while (have && head.cyc < cyc) begin
      total++;
      bad++;
      $display("[TB] FAIL missed_out%0d: nothing seen, required en=%0b fd=%0b data=%0d at cyc %0d",
               sel5 ? 5 : 4, head.en, head.fd, head.data, head.cyc);
      if (sel5) void'(q5.pop_front());
      else      void'(q4.pop_front());
      have = sel5 ? (q5.size() > 0) : (q4.size() > 0);
      if (have) head = sel5 ? q5[0] : q4[0];
    end
    if (en || fd) begin
      total++;
      if (!have || head.cyc != cyc) begin
        bad++;
        $display("[TB] FAIL unexpected_out%0d: en=%0b fd=%0b data=%0d at cyc %0d, required none",
                 sel5 ? 5 : 4, en, fd, d, cyc);
      end else begin
        if (sel5) void'(q5.pop_front());
        else      void'(q4.pop_front());
        if (en !== head.en || fd !== head.fd || (head.en && d !== head.data)) begin
          bad++;
          $display("[TB] FAIL out%0d: en=%0b fd=%0b data=%0d, required en=%0b fd=%0b data=%0d (cyc %0d)",
                   sel5 ? 5 : 4, en, fd, d, head.en, head.fd, head.data, cyc);
        end
      end
    end
  endtask

  // Monitor runs on the falling edge, clear of the edge the DUT updates on
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput(1'b0, o_en4, o_fd4, o_data4);
      checkOutput(1'b1, o_en5, o_fd5, o_data5);
    end
  end

  task automatic checkReset();
    logic [15:0] got [6];
    got[0] = 16'(o_en4); got[1] = 16'(o_fd4); got[2] = o_data4;
    got[3] = 16'(o_en5); got[4] = 16'(o_fd5); got[5] = o_data5;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got[i] !== 16'd0) begin
        bad++;
        $display("[TB] FAIL reset_%0d: got %0d, required 0", i, got[i]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; mode = 1'b0; relu = 1'b0;
    en4 = 1'b0; en5 = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    checkReset();
    rst = 1'b0;
    idle(2);

    $display("[TB] 4x4 pool, 1..16");
    for (int k = 1; k <= 16; k++)
      applyStimulus(0, k, 1, 0, (k == 6 || k == 8 || k == 14 || k == 16), k, k == 16);
    idle(3);

    $display("[TB] 4x4 pool + relu, sample 6 = -100, random gaps");
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, (k == 6) ? -100 : k, 1, 1,
                    (k == 6 || k == 8 || k == 14 || k == 16), (k == 6) ? 5 : k, k == 16);
      idle($urandom_range(0, 3));
    end
    idle(3);

    $display("[TB] 5x5 pool, 1..25");
    for (int k = 1; k <= 25; k++)
      applyStimulus(1, k, 1, 0, (k == 7 || k == 9 || k == 17 || k == 19), k, k == 25);
    idle(3);

    $display("[TB] 4x4 bypass + relu, mode toggled mid-frame");
    for (int k = 1; k <= 16; k++)
      applyStimulus(0, (k % 2 == 1) ? 3 : -3, k >= 8, 1, 1, (k % 2 == 1) ? 3 : 0, k == 16);
    idle(3);

    $display("[TB] back-to-back frames");
    for (int k = 1; k <= 16; k++)
      applyStimulus(0, k, 1, 0, (k == 6 || k == 8 || k == 14 || k == 16), k, k == 16);
    for (int k = 1; k <= 16; k++)
      applyStimulus(0, 100 + k, 1, 0, (k == 6 || k == 8 || k == 14 || k == 16), 100 + k, k == 16);
    idle(3);

    for (int a = 0; a < 2; a++) begin
      $display("[TB] abort after pixel 10 via %s", (a == 0) ? "clear" : "reset");
      for (int k = 1; k <= 10; k++)
        applyStimulus(0, k, 1, 0, (k == 6 || k == 8), k, 0);
      abortFrame(a == 1);
      idle(2);
      for (int k = 1; k <= 16; k++)
        applyStimulus(0, k, 1, 0, (k == 6 || k == 8 || k == 14 || k == 16), k, k == 16);
      idle(3);
    end

    idle(5);
    total++;
    if (q4.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain4: %0d results still pending, required 0", q4.size());
    end
    total++;
    if (q5.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain5: %0d results still pending, required 0", q5.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
